// File: rtl/mat_pair_loader_if.sv
// Element-stream input and matrix-pair output bundle for mat_pair_loader.
// slave is the loader side; master is the feeder/consumer side.
interface mat_pair_loader_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
);
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [4*W-1:0]   A;
    logic [4*W-1:0]   B;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic [CNT_W-1:0] pair_count;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, A, B, out_valid, err, pair_count
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, A, B, out_valid, err, pair_count
    );
endinterface

// File: rtl/mat_pair_loader.sv
// Assembles eight serial signed elements into a packed A/B 2x2 matrix pair.
// One assembly buffer plus one output register lets loading overlap draining.
module mat_pair_loader #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mat_pair_loader_if.slave bus
);
    localparam int unsigned MAT_W  = 4 * W;
    localparam int unsigned N_ELEM = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_asm [N_ELEM];
    logic [MAT_W-1:0] r_a;
    logic [MAT_W-1:0] r_b;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_err;
    logic [CNT_W-1:0] r_pair_count;

    logic             w_accept;
    logic             w_out_hs;
    logic             w_at_last;
    logic             w_frame_ok;
    logic [MAT_W-1:0] w_asm_a;
    logic [MAT_W-1:0] w_asm_b;
    logic [MAT_W-1:0] w_fin_b;

    // Handshake decode and pair images; w_fin_b folds in the element arriving now.
    always_comb begin
        w_accept   = bus.in_valid && r_in_ready;
        w_out_hs   = r_out_valid && bus.out_ready;
        w_at_last  = (r_idx == LAST_IDX);
        w_frame_ok = (bus.in_last == w_at_last);
        w_asm_a    = {r_asm[0], r_asm[1], r_asm[2], r_asm[3]};
        w_asm_b    = {r_asm[4], r_asm[5], r_asm[6], r_asm[7]};
        w_fin_b    = {r_asm[4], r_asm[5], r_asm[6], bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_idx        <= '0;
            r_asm        <= '{default: '0};
            r_a          <= '0;
            r_b          <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_pair_count <= '0;
        end else begin
            // A drained pair empties the output unless a refill below overrides it.
            if (w_out_hs) begin
                r_pair_count <= r_pair_count + CNT_W'(1);
                r_out_valid  <= 1'b0;
            end
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (!w_frame_ok) begin
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else if (w_at_last) begin
                            r_idx <= '0;
                            if (!r_out_valid || bus.out_ready) begin
                                r_a         <= w_asm_a;
                                r_b         <= w_fin_b;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_asm[LAST_IDX] <= bus.in_data;
                                r_state         <= S_HOLD;
                                r_in_ready      <= 1'b0;
                            end
                        end else begin
                            r_asm[r_idx] <= bus.in_data;
                            r_idx        <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (w_out_hs) begin
                        r_a         <= w_asm_a;
                        r_b         <= w_asm_b;
                        r_out_valid <= 1'b1;
                        r_state     <= S_LOAD;
                        r_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.err        = r_err;
    assign bus.pair_count = r_pair_count;
endmodule
